// File: rtl/spi_controller.sv
// SPI mode-0 initiator: serialises one 16-bit {wr, addr, wdata} frame per accepted start, MSB first.
// Optional one-entry command buffer is enabled with `define SPI_CTRL_CMD_BUF_EN.
module spi_controller #(
  parameter int CLK_DIV  = 8,
  parameter int CS_SETUP = 4,
  parameter int CS_HOLD  = 4,
  parameter int CS_GAP   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       wr,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic       ncs,
  output logic       sclk,
  output logic       copi
);

  localparam int MAX_A   = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int MAX_B   = (CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP;
  localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(CS_SETUP);
  localparam logic [CNT_W-1:0] DIV_LD   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(CS_HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(CS_GAP - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [3:0]       bitn, bitn_d;
  logic [15:0]      shreg, shreg_d;
  logic             ncs_d, sclk_d, copi_d, busy_d, done_d;
  logic [15:0]      cmd;

  assign cmd = {wr, addr, wdata};

`ifdef SPI_CTRL_CMD_BUF_EN
  logic        buf_valid, buf_valid_d;
  logic [15:0] buf_data, buf_data_d;
`endif

  // All outputs are flops so nothing combinational reaches the pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      bitn  <= '0;
      shreg <= '0;
      ncs   <= 1'b1;
      sclk  <= 1'b0;
      copi  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef SPI_CTRL_CMD_BUF_EN
      buf_valid <= 1'b0;
      buf_data  <= '0;
`endif
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      bitn  <= bitn_d;
      shreg <= shreg_d;
      ncs   <= ncs_d;
      sclk  <= sclk_d;
      copi  <= copi_d;
      busy  <= busy_d;
      done  <= done_d;
`ifdef SPI_CTRL_CMD_BUF_EN
      buf_valid <= buf_valid_d;
      buf_data  <= buf_data_d;
`endif
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    bitn_d  = bitn;
    shreg_d = shreg;
    ncs_d   = ncs;
    sclk_d  = sclk;
    copi_d  = copi;
    busy_d  = busy;
    done_d  = 1'b0;
`ifdef SPI_CTRL_CMD_BUF_EN
    buf_valid_d = buf_valid;
    buf_data_d  = buf_data;
`endif

    case (state)
      IDLE: begin
`ifdef SPI_CTRL_CMD_BUF_EN
        if (buf_valid) begin
          state_d     = SETUP;
          cnt_d       = SETUP_LD;
          shreg_d     = buf_data;
          buf_valid_d = start;
          buf_data_d  = start ? cmd : buf_data;
        end else if (start) begin
          state_d = SETUP;
          cnt_d   = SETUP_LD;
          shreg_d = cmd;
        end
`else
        if (start) begin
          state_d = SETUP;
          cnt_d   = SETUP_LD;
          shreg_d = cmd;
        end
`endif
      end

      // ncs drops on the first SETUP edge, so setup spans CS_SETUP+1 counter steps.
      SETUP: begin
        ncs_d  = 1'b0;
        sclk_d = 1'b0;
        copi_d = shreg[15];
        busy_d = 1'b1;
        if (cnt == '0) begin
          state_d = SHIFT;
          sclk_d  = 1'b1;
          cnt_d   = DIV_LD;
          bitn_d  = '0;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end

      SHIFT: begin
        if (cnt != '0) begin
          cnt_d = cnt - 1'b1;
        end else if (sclk) begin
          sclk_d = 1'b0;
          cnt_d  = DIV_LD;
          if (bitn != 4'd15) begin
            shreg_d = {shreg[14:0], 1'b0};
            copi_d  = shreg[14];
          end
        end else if (bitn == 4'd15) begin
          state_d = HOLD;
          cnt_d   = HOLD_LD;
        end else begin
          sclk_d = 1'b1;
          bitn_d = bitn + 1'b1;
          cnt_d  = DIV_LD;
        end
      end

      HOLD: begin
        if (cnt == '0) begin
          state_d = GAP;
          ncs_d   = 1'b1;
          copi_d  = 1'b0;
          cnt_d   = GAP_LD;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end

      GAP: begin
        if (cnt == '0) begin
          done_d = 1'b1;
`ifdef SPI_CTRL_CMD_BUF_EN
          if (buf_valid) begin
            state_d     = SETUP;
            cnt_d       = SETUP_LD;
            shreg_d     = buf_data;
            buf_valid_d = 1'b0;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
`else
          state_d = IDLE;
          busy_d  = 1'b0;
`endif
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        ncs_d   = 1'b1;
        sclk_d  = 1'b0;
        copi_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase

`ifdef SPI_CTRL_CMD_BUF_EN
    // A start arriving mid-frame parks in the buffer if it is free; otherwise it is dropped.
    if (start && (state != IDLE) && !buf_valid) begin
      buf_valid_d = 1'b1;
      buf_data_d  = cmd;
    end
`endif
  end

endmodule

// File: tb/tb_spi_controller.sv
// Scoreboard bench for spi_controller: a driver queues expected frames/done times, while
// independent monitors decode the SPI pins and the done pulse and compare against the queues.
module tb_spi_controller;

  localparam int CLK_DIV  = 8;
  localparam int CS_SETUP = 4;
  localparam int CS_HOLD  = 4;
  localparam int CS_GAP   = 8;
  localparam int LAT      = 273;
`ifdef SPI_CTRL_CMD_BUF_EN
  localparam logic [7:0] REG2_EXP = 8'hFF;
`else
  localparam logic [7:0] REG2_EXP = 8'h00;
`endif

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       wr;
  logic [6:0] addr;
  logic [7:0] wdata;
  logic       busy;
  logic       done;
  logic       ncs;
  logic       sclk;
  logic       copi;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  logic [15:0] exp_frames[$];
  int          exp_done[$];
  logic [7:0]  periph_regs[5];

  int          bit_cnt = 0;
  logic [15:0] shin = '0;
  int          ncs_fall_cyc = 0;
  int          ncs_rise_cyc = 0;
  int          last_rise = 0;
  int          last_fall = 0;
  int          phase_err = 0;
  int          busy_err = 0;
  bit          check_gap = 1'b0;
  logic        prev_ncs = 1'b1;
  logic        prev_sclk = 1'b0;
  logic        prev_copi = 1'b0;

  spi_controller #(
    .CLK_DIV (CLK_DIV),
    .CS_SETUP(CS_SETUP),
    .CS_HOLD (CS_HOLD),
    .CS_GAP  (CS_GAP)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .wr   (wr),
    .addr (addr),
    .wdata(wdata),
    .busy (busy),
    .done (done),
    .ncs  (ncs),
    .sclk (sclk),
    .copi (copi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic fail_now(input string name, input int actual);
    tests_run++;
    tests_failed++;
    $display("[TB] FAIL %s: got %0d, expected none", name, actual);
  endtask

  // Drive one start strobe; when the command should be taken, queue its expected frame.
  task automatic apply_stimulus(input logic w, input logic [6:0] a, input logic [7:0] d,
                                input bit accept, output int acc);
    @(negedge clk);
    start = 1'b1;
    wr    = w;
    addr  = a;
    wdata = d;
    @(posedge clk);
    #1;
    acc   = cyc;
    start = 1'b0;
    wr    = 1'b0;
    addr  = '0;
    wdata = '0;
    if (accept) exp_frames.push_back({w, a, d});
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || !ncs || exp_done.size() != 0) && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 3000) fail_now("idle_timeout", n);
    repeat (3) @(posedge clk);
  endtask

  // SPI pin monitor: rebuilds each frame at sclk rises and acts as the register file.
  always begin
    @(posedge clk);
    #1;
    if (prev_ncs && !ncs) begin
      if (check_gap) begin
        check_output("ncs_gap", cyc - ncs_rise_cyc, CS_GAP + 1);
        check_gap = 1'b0;
      end
      bit_cnt      = 0;
      shin         = '0;
      phase_err    = 0;
      busy_err     = 0;
      ncs_fall_cyc = cyc;
    end
    if (!ncs) begin
      if (!busy) busy_err++;
      if (sclk && !prev_sclk) begin
        if (bit_cnt == 0) begin
          if (cyc - ncs_fall_cyc != CS_SETUP) phase_err++;
        end else if (cyc - last_fall != CLK_DIV) begin
          phase_err++;
        end
        shin      = {shin[14:0], copi};
        bit_cnt++;
        last_rise = cyc;
      end
      if (!sclk && prev_sclk) begin
        if (cyc - last_rise != CLK_DIV) phase_err++;
        last_fall = cyc;
      end
      if (sclk && prev_sclk && (copi != prev_copi)) phase_err++;
    end
    if (!prev_ncs && ncs) begin
      ncs_rise_cyc = cyc;
      if (bit_cnt == 16) begin
        if (cyc - last_fall != CLK_DIV + CS_HOLD) phase_err++;
        if (exp_frames.size() == 0) begin
          fail_now("unexpected_frame", int'(shin));
        end else begin
          check_output("frame_bits", shin, exp_frames.pop_front());
          check_output("frame_timing", phase_err, 0);
          check_output("busy_in_frame", busy_err, 0);
        end
        if (shin[15] && shin[14:8] <= 7'd4) periph_regs[shin[10:8]] = shin[7:0];
      end
    end
    prev_ncs  = ncs;
    prev_sclk = sclk;
    prev_copi = copi;
  end

  // Done monitor: every pulse must line up with the next queued completion cycle.
  always begin
    @(posedge clk);
    #1;
    if (done) begin
      if (exp_done.size() == 0) fail_now("unexpected_done", cyc);
      else check_output("done_cycle", cyc, exp_done.pop_front());
    end
  end

  initial begin
    int acc1;
    int acc2;
    int n;
    for (int i = 0; i < 5; i++) periph_regs[i] = 8'h00;
    start = 1'b0;
    wr    = 1'b0;
    addr  = '0;
    wdata = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_ncs", ncs, 1'b1);
    check_output("reset_sclk", sclk, 1'b0);
    check_output("reset_copi", copi, 1'b0);
    check_output("reset_busy", busy, 1'b0);
    check_output("reset_done", done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Test 1: frame 0x8480 and full-frame latency.
    apply_stimulus(1'b1, 7'h04, 8'h80, 1'b1, acc1);
    exp_done.push_back(acc1 + LAT);
    wait_idle();
    check_output("t1_pwm_reg", periph_regs[4], 8'h80);

    // Test 2: alternating data pattern to register 0.
    apply_stimulus(1'b1, 7'h00, 8'hA5, 1'b1, acc1);
    exp_done.push_back(acc1 + LAT);
    wait_idle();
    check_output("t2_reg0", periph_regs[0], 8'hA5);

    // Test 3: a second start ten cycles in must not disturb the running frame.
    apply_stimulus(1'b1, 7'h03, 8'h5A, 1'b1, acc1);
    exp_done.push_back(acc1 + LAT);
    repeat (9) @(posedge clk);
`ifdef SPI_CTRL_CMD_BUF_EN
    apply_stimulus(1'b1, 7'h02, 8'hFF, 1'b1, acc2);
    exp_done.push_back(acc1 + 2 * LAT);
`else
    apply_stimulus(1'b1, 7'h02, 8'hFF, 1'b0, acc2);
`endif
    check_output("t3_busy_after_2nd", busy, 1'b1);
    wait_idle();
    check_output("t3_reg3", periph_regs[3], 8'h5A);
    check_output("t3_reg2", periph_regs[2], REG2_EXP);

    // Test 4: abort at the ninth sclk rise, then a clean write.
    apply_stimulus(1'b1, 7'h01, 8'hC3, 1'b0, acc1);
    n = 0;
    while (bit_cnt < 9 && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 1000) fail_now("rise9_timeout", n);
    rst_n = 1'b0;
    #1;
    check_output("abort_ncs", ncs, 1'b1);
    check_output("abort_sclk", sclk, 1'b0);
    check_output("abort_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    check_output("t4_reg1_untouched", periph_regs[1], 8'h00);
    apply_stimulus(1'b1, 7'h01, 8'h3C, 1'b1, acc1);
    exp_done.push_back(acc1 + LAT);
    wait_idle();
    check_output("t4_reg1", periph_regs[1], 8'h3C);

    // Test 5: out-of-range address and a read-type frame leave the registers alone.
    apply_stimulus(1'b1, 7'h05, 8'h11, 1'b1, acc1);
    exp_done.push_back(acc1 + LAT);
    wait_idle();
    apply_stimulus(1'b0, 7'h02, 8'h22, 1'b1, acc1);
    exp_done.push_back(acc1 + LAT);
    wait_idle();
    check_output("t5_regs", {periph_regs[0], periph_regs[1], periph_regs[2], periph_regs[3]},
                 {8'hA5, 8'h3C, REG2_EXP, 8'h5A});
    check_output("t5_reg4", periph_regs[4], 8'h80);

`ifdef SPI_CTRL_CMD_BUF_EN
    // Test 6: three back-to-back starts; the buffered one follows, the third is dropped.
    apply_stimulus(1'b1, 7'h00, 8'h11, 1'b1, acc1);
    exp_done.push_back(acc1 + LAT);
    apply_stimulus(1'b1, 7'h01, 8'h22, 1'b1, acc2);
    exp_done.push_back(acc1 + 2 * LAT);
    apply_stimulus(1'b1, 7'h02, 8'h33, 1'b0, acc2);
    check_gap = 1'b1;
    n = 0;
    while (!done && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 400) fail_now("t6_done_timeout", n);
    check_output("t6_busy_between", busy, 1'b1);
    wait_idle();
    check_output("t6_regs", {periph_regs[0], periph_regs[1], periph_regs[2]},
                 {8'h11, 8'h22, 8'hFF});
`endif

    check_output("queues_empty", exp_frames.size() + exp_done.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
